// File: rtl/pc_next_unit_if.sv
// pc_next_unit_if: groups the per-cycle control-flow inputs and the next-address /
// return-stack status outputs of pc_next_unit.
//   master modport: the decoder/PC side drives bios_reset, hlt, pc_in, op, cond and target,
//                   and receives address, depth, overflow and underflow.
//   slave modport : the pc_next_unit side (the reverse directions).
interface pc_next_unit_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic             bios_reset;
  logic             hlt;
  logic [WIDTH-1:0] pc_in;
  logic [2:0]       op;
  logic             cond;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] address;
  logic [DW-1:0]    depth;
  logic             overflow;
  logic             underflow;

  modport master (
    output bios_reset, hlt, pc_in, op, cond, target,
    input  address, depth, overflow, underflow
  );

  modport slave (
    input  bios_reset, hlt, pc_in, op, cond, target,
    output address, depth, overflow, underflow
  );
endinterface

// File: rtl/pc_next_unit.sv
// pc_next_unit: next-address generator upstream of the PC register.
// Produces the next PC combinationally from pc_in and the decoded operation, and keeps a
// circular return-address stack with sticky overflow/underflow flags.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-high clear of depth, flags and top pointer
//   bus   : pc_next_unit_if.slave
//           bios_reset (sync clear), hlt (freeze), pc_in, op, cond, target  -> inputs
//           address (combinational), depth, overflow, underflow (registered) -> outputs
module pc_next_unit #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input logic            clk,
  input logic            reset,
  pc_next_unit_if.slave  bus
);
  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [2:0] OpSeq   = 3'b000;
  localparam logic [2:0] OpJmp   = 3'b001;
  localparam logic [2:0] OpBrz   = 3'b010;
  localparam logic [2:0] OpCall  = 3'b011;
  localparam logic [2:0] OpRet   = 3'b100;
  localparam logic [2:0] OpBrrel = 3'b101;

  localparam logic [DW-1:0]    DepthFull = DW'(DEPTH);
  localparam logic [DW-1:0]    DepthOne  = DW'(1);
  localparam logic [PW-1:0]    PtrOne    = PW'(1);
  localparam logic [WIDTH-1:0] AddrOne   = WIDTH'(1);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] address;
  logic             push;
  logic             pop;
  logic             ret_empty;

  assign pc_inc = bus.pc_in + AddrOne;

  // Address decode; push/pop are only raised when no higher-priority control is active,
  // so stack updates always agree with what the PC register loads.
  always_comb begin
    address   = pc_inc;
    push      = 1'b0;
    pop       = 1'b0;
    ret_empty = 1'b0;
    if (reset || bus.bios_reset) begin
      address = '0;
    end else if (bus.hlt) begin
      address = bus.pc_in;
    end else begin
      case (bus.op)
        OpJmp:   address = bus.target;
        OpBrz:   address = bus.cond ? bus.target : pc_inc;
        OpCall: begin
          address = bus.target;
          push    = 1'b1;
        end
        OpRet: begin
          if (depth_q != '0) begin
            address = stack_q[top_q];
            pop     = 1'b1;
          end else begin
            ret_empty = 1'b1;
          end
        end
        // Offset is two's complement; modular addition handles the sign.
        OpBrrel: address = bus.cond ? (pc_inc + bus.target) : pc_inc;
        default: address = pc_inc;
      endcase
    end
  end

  always_comb begin
    top_d       = top_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.bios_reset) begin
      top_d       = '0;
      depth_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (push) begin
      top_d = top_q + PtrOne;
      if (depth_q == DepthFull) begin
        overflow_d = 1'b1;
      end else begin
        depth_d = depth_q + DepthOne;
      end
    end else if (pop) begin
      top_d   = top_q - PtrOne;
      depth_d = depth_q - DepthOne;
    end else if (ret_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q       <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      top_q       <= top_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: entries are only read when depth says they are valid.
  // The push lands at the advanced pointer; when full this overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[top_q + PtrOne] <= pc_inc;
    end
  end

  assign bus.address   = address;
  assign bus.depth     = depth_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;
  localparam int unsigned WIDTH = 10;
  localparam int unsigned DEPTH = 8;

  localparam logic [2:0] OpSeq   = 3'b000;
  localparam logic [2:0] OpJmp   = 3'b001;
  localparam logic [2:0] OpBrz   = 3'b010;
  localparam logic [2:0] OpCall  = 3'b011;
  localparam logic [2:0] OpRet   = 3'b100;
  localparam logic [2:0] OpBrrel = 3'b101;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_next_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_next_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] pc,
                       input logic [WIDTH-1:0] tgt, input logic c);
    bus.op     = op;
    bus.pc_in  = pc;
    bus.target = tgt;
    bus.cond   = c;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset          = 1'b1;
    bus.bios_reset = 1'b0;
    bus.hlt        = 1'b0;
    bus.op         = OpSeq;
    bus.pc_in      = 10'h3FF;
    bus.target     = '0;
    bus.cond       = 1'b0;
    #2;
    check("reset_addr", 32'(bus.address), 32'h000);
    check("reset_depth", 32'(bus.depth), 32'd0);
    check("reset_ovf", 32'(bus.overflow), 32'd0);
    check("reset_unf", 32'(bus.underflow), 32'd0);
    #10;
    reset = 1'b0;
    tick();

    // SEQ wraps at the top of the address space
    drive(OpSeq, 10'h3FF, 10'h000, 1'b0);
    check("seq_wrap", 32'(bus.address), 32'h000);

    // CALL then RET
    drive(OpCall, 10'h020, 10'h100, 1'b0);
    check("call_addr", 32'(bus.address), 32'h100);
    tick();
    check("call_depth", 32'(bus.depth), 32'd1);
    drive(OpRet, 10'h105, 10'h000, 1'b0);
    check("ret_addr", 32'(bus.address), 32'h021);
    tick();
    check("ret_depth", 32'(bus.depth), 32'd0);

    // Nine CALLs: saturate at DEPTH, overflow on the ninth
    for (int i = 0; i < 9; i++) begin
      drive(OpCall, 10'(10'h010 + i), 10'h200, 1'b0);
      check("call9_addr", 32'(bus.address), 32'h200);
      tick();
      check("call9_depth", 32'(bus.depth), (i < 8) ? 32'(i + 1) : 32'd8);
      check("call9_ovf", 32'(bus.overflow), (i == 8) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(OpRet, 10'h300, 10'h000, 1'b0);
      check("ret8_addr", 32'(bus.address), 32'(10'h019 - i));
      tick();
      check("ret8_depth", 32'(bus.depth), 32'(7 - i));
    end
    check("ret8_unf", 32'(bus.underflow), 32'd0);
    check("ret8_ovf_sticky", 32'(bus.overflow), 32'd1);

    // RET on empty stack
    drive(OpRet, 10'h050, 10'h000, 1'b0);
    check("ret_empty_addr", 32'(bus.address), 32'h051);
    tick();
    check("ret_empty_unf", 32'(bus.underflow), 32'd1);
    check("ret_empty_depth", 32'(bus.depth), 32'd0);
    drive(OpSeq, 10'h051, 10'h000, 1'b0);
    tick();
    check("unf_sticky", 32'(bus.underflow), 32'd1);
    bus.bios_reset = 1'b1;
    drive(OpSeq, 10'h052, 10'h000, 1'b0);
    check("bios_addr", 32'(bus.address), 32'h000);
    tick();
    bus.bios_reset = 1'b0;
    check("bios_unf", 32'(bus.underflow), 32'd0);
    check("bios_ovf", 32'(bus.overflow), 32'd0);

    // Branches and other decodes
    drive(OpBrrel, 10'h004, 10'h3FA, 1'b1);
    check("brrel_taken", 32'(bus.address), 32'h3FF);
    drive(OpBrrel, 10'h004, 10'h3FA, 1'b0);
    check("brrel_not", 32'(bus.address), 32'h005);
    drive(OpBrrel, 10'h3FE, 10'h003, 1'b1);
    check("brrel_wrap", 32'(bus.address), 32'h002);
    drive(OpBrz, 10'h040, 10'h2AA, 1'b1);
    check("brz_taken", 32'(bus.address), 32'h2AA);
    drive(OpBrz, 10'h040, 10'h2AA, 1'b0);
    check("brz_not", 32'(bus.address), 32'h041);
    drive(OpJmp, 10'h040, 10'h155, 1'b0);
    check("jmp", 32'(bus.address), 32'h155);
    drive(3'b110, 10'h040, 10'h155, 1'b1);
    check("op110_seq", 32'(bus.address), 32'h041);
    drive(3'b111, 10'h123, 10'h155, 1'b1);
    check("op111_seq", 32'(bus.address), 32'h124);

    // hlt freezes
    bus.hlt = 1'b1;
    drive(OpCall, 10'h123, 10'h200, 1'b0);
    check("hlt_addr", 32'(bus.address), 32'h123);
    tick();
    bus.hlt = 1'b0;
    check("hlt_depth", 32'(bus.depth), 32'd0);

    // bios_reset overrides CALL
    bus.bios_reset = 1'b1;
    drive(OpCall, 10'h123, 10'h200, 1'b0);
    check("bios_call_addr", 32'(bus.address), 32'h000);
    tick();
    bus.bios_reset = 1'b0;
    check("bios_call_depth", 32'(bus.depth), 32'd0);

    // RET right after CALL returns the value just pushed
    drive(OpCall, 10'h070, 10'h180, 1'b0);
    tick();
    drive(OpRet, 10'h180, 10'h000, 1'b0);
    check("ret_after_call", 32'(bus.address), 32'h071);
    tick();

    // Async reset mid-cycle with depth=3
    for (int i = 0; i < 3; i++) begin
      drive(OpCall, 10'(10'h0A0 + i), 10'h1C0, 1'b0);
      tick();
    end
    check("pre_async_depth", 32'(bus.depth), 32'd3);
    drive(OpCall, 10'h0B0, 10'h1C0, 1'b0);
    reset = 1'b1;
    #1;
    check("async_depth", 32'(bus.depth), 32'd0);
    check("async_addr", 32'(bus.address), 32'h000);
    #2;
    bus.op = OpSeq;
    reset  = 1'b0;
    tick();
    check("post_async_depth", 32'(bus.depth), 32'd0);
    drive(OpSeq, 10'h0B0, 10'h000, 1'b0);
    check("post_async_seq", 32'(bus.address), 32'h0B1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
